// File: rtl/rom_aleatoria_multipuerto.sv
// Multi-port lazy-random memory model: each address takes the next LFSR word on first access
// and keeps it; optional write port turns it into a randomly initialised RAM.
module rom_aleatoria_multipuerto #(
  parameter int unsigned D_WIDTH   = 32,
  parameter int unsigned MEM_DEPTH = 1024,
  parameter int unsigned N_PORTS   = 2,
  parameter int unsigned LATENCY   = 1,
  parameter logic [31:0] SEED      = 32'hACE12468,
  parameter bit          WRITABLE  = 1'b0,
  localparam int unsigned A_WIDTH  = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1,
  localparam int unsigned C_WIDTH  = $clog2(MEM_DEPTH + 1)
) (
  input  logic                         CLK,
  input  logic                         RST_N,
  input  logic [N_PORTS-1:0]           req_valid,
  input  logic [N_PORTS*A_WIDTH-1:0]   req_addr,
  output logic [N_PORTS-1:0]           rsp_valid,
  output logic [N_PORTS*D_WIDTH-1:0]   rsp_data,
  output logic [N_PORTS-1:0]           rsp_err,
  input  logic                         we,
  input  logic [A_WIDTH-1:0]           waddr,
  input  logic [D_WIDTH-1:0]           wdata,
  output logic [C_WIDTH-1:0]           fill_count
);

  localparam logic [31:0] SeedEff   = (SEED == 32'h0) ? 32'h1 : SEED;
  localparam bit          FullRange = (MEM_DEPTH == (32'd1 << A_WIDTH));

  function automatic logic [31:0] lfsr_next(input logic [31:0] s);
    return (s >> 1) ^ (s[0] ? 32'h8020_0003 : 32'h0);
  endfunction

  logic [A_WIDTH-1:0]                addr [N_PORTS];
  logic [N_PORTS-1:0]                rd_ok, rd_fill, rd_dup;
  logic [N_PORTS-1:0][D_WIDTH-1:0]   rd_data;
  logic                              wr_ok, wr_en;
  logic [31:0]                       lfsr_q, lfsr_d;
  logic [MEM_DEPTH-1:0]              filled_q, filled_d;
  logic [C_WIDTH-1:0]                fill_q, fill_d;
  logic [D_WIDTH-1:0]                mem_q [MEM_DEPTH];
  int unsigned                       n_new, fill_sum;

  logic [LATENCY-1:0][N_PORTS-1:0]              vld_q, err_q;
  logic [LATENCY-1:0][N_PORTS-1:0][D_WIDTH-1:0] dat_q;

  for (genvar p = 0; p < N_PORTS; p++) begin : g_port
    assign addr[p] = req_addr[p*A_WIDTH +: A_WIDTH];
    if (FullRange) begin : g_full
      assign rd_ok[p] = 1'b1;
    end else begin : g_part
      assign rd_ok[p] = 32'(addr[p]) < MEM_DEPTH;
    end
  end

  if (FullRange) begin : g_wfull
    assign wr_ok = 1'b1;
  end else begin : g_wpart
    assign wr_ok = 32'(waddr) < MEM_DEPTH;
  end

  assign wr_en = WRITABLE && we && wr_ok;

  // Ports resolved in index order; a repeat of an earlier port's address reuses its word,
  // so one address fills at most once per edge and fills chain through the LFSR.
  always_comb begin
    lfsr_d  = lfsr_q;
    rd_data = '0;
    rd_fill = '0;
    rd_dup  = '0;
    for (int p = 0; p < N_PORTS; p++) begin
      if (req_valid[p] && rd_ok[p]) begin
        for (int q = 0; q < p; q++) begin
          if (!rd_dup[p] && req_valid[q] && rd_ok[q] && (addr[q] == addr[p])) begin
            rd_dup[p]  = 1'b1;
            rd_data[p] = rd_data[q];
          end
        end
        if (!rd_dup[p]) begin
          if (filled_q[addr[p]]) begin
            rd_data[p] = mem_q[addr[p]];
          end else begin
            rd_data[p] = lfsr_d[D_WIDTH-1:0];
            lfsr_d     = lfsr_next(lfsr_d);
            rd_fill[p] = 1'b1;
          end
        end
      end
    end
  end

  always_comb begin
    filled_d = filled_q;
    n_new    = 0;
    for (int p = 0; p < N_PORTS; p++) begin
      if (rd_fill[p]) begin
        filled_d[addr[p]] = 1'b1;
        n_new++;
      end
    end
    if (wr_en) begin
      if (!filled_d[waddr]) n_new++;
      filled_d[waddr] = 1'b1;
    end
    fill_sum = 32'(fill_q) + n_new;
    fill_d   = (fill_sum >= MEM_DEPTH) ? C_WIDTH'(MEM_DEPTH) : C_WIDTH'(fill_sum);
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      lfsr_q   <= SeedEff;
      filled_q <= '0;
      fill_q   <= '0;
      vld_q    <= '0;
      err_q    <= '0;
      dat_q    <= '0;
    end else begin
      lfsr_q   <= lfsr_d;
      filled_q <= filled_d;
      fill_q   <= fill_d;
      vld_q[0] <= req_valid;
      err_q[0] <= req_valid & ~rd_ok;
      dat_q[0] <= rd_data;
      for (int i = 1; i < LATENCY; i++) begin
        vld_q[i] <= vld_q[i-1];
        err_q[i] <= err_q[i-1];
        dat_q[i] <= dat_q[i-1];
      end
    end
  end

  // Contents need no reset: the filled bitmap gates every read. Write lands after fills.
  always_ff @(posedge CLK) begin
    for (int p = 0; p < N_PORTS; p++) begin
      if (rd_fill[p]) mem_q[addr[p]] <= rd_data[p];
    end
    if (wr_en) mem_q[waddr] <= wdata;
  end

  assign rsp_valid  = vld_q[LATENCY-1];
  assign rsp_err    = err_q[LATENCY-1];
  assign rsp_data   = dat_q[LATENCY-1];
  assign fill_count = fill_q;

endmodule

// File: tb/tb_rom_aleatoria_multipuerto.sv
// Bench: default ROM instance and a 3-port writable 1000-word LATENCY=3 instance, both checked
// against a sequential reference model of the fill/read/write rules.
module tb_rom_aleatoria_multipuerto;

  localparam int AW = 10;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_a_n = 1'b1, rst_b_n = 1'b1;

  logic [1:0]      va;
  logic [AW-1:0]   aa [2];
  logic [2*AW-1:0] addr_a;
  logic [1:0]      rv_a, re_a;
  logic [63:0]     rd_a;
  logic [10:0]     fc_a;
  logic            we_a = 1'b0;
  logic [AW-1:0]   waddr_a = '0;
  logic [31:0]     wdata_a = '0;

  logic [2:0]      vb;
  logic [AW-1:0]   ab [3];
  logic [3*AW-1:0] addr_b;
  logic [2:0]      rv_b, re_b;
  logic [95:0]     rd_b;
  logic [9:0]      fc_b;
  logic            we_b;
  logic [AW-1:0]   waddr_b;
  logic [31:0]     wdata_b;

  assign addr_a = {aa[1], aa[0]};
  assign addr_b = {ab[2], ab[1], ab[0]};

  rom_aleatoria_multipuerto dut_a (
    .CLK(clk), .RST_N(rst_a_n), .req_valid(va), .req_addr(addr_a), .rsp_valid(rv_a),
    .rsp_data(rd_a), .rsp_err(re_a), .we(we_a), .waddr(waddr_a), .wdata(wdata_a),
    .fill_count(fc_a)
  );

  rom_aleatoria_multipuerto #(
    .D_WIDTH(32), .MEM_DEPTH(1000), .N_PORTS(3), .LATENCY(3), .WRITABLE(1'b1)
  ) dut_b (
    .CLK(clk), .RST_N(rst_b_n), .req_valid(vb), .req_addr(addr_b), .rsp_valid(rv_b),
    .rsp_data(rd_b), .rsp_err(re_b), .we(we_b), .waddr(waddr_b), .wdata(wdata_b),
    .fill_count(fc_b)
  );

  typedef struct {
    int          due;
    int          port;
    logic        err;
    logic [31:0] data;
  } exp_t;

  exp_t        q_a[$], q_b[$];
  logic [31:0] m_lfsr [2];
  int          m_cnt [2];
  logic [31:0] m_mem [2][1024];
  bit          m_fill [2][1024];
  int          cyc = 0;
  int          n_checks = 0, n_errors = 0;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic model_reset(input int id);
    m_lfsr[id] = 32'hACE12468;
    m_cnt[id]  = 0;
    for (int i = 0; i < 1024; i++) m_fill[id][i] = 1'b0;
  endtask

  task automatic model_read(input int id, input int port, input int addr, input int depth,
                            input int lat);
    exp_t e;
    bit   lsb;
    e.due = cyc + lat; e.port = port; e.err = 1'b0; e.data = 32'h0;
    if (addr >= depth) begin
      e.err = 1'b1;
    end else begin
      if (!m_fill[id][addr]) begin
        m_mem[id][addr]  = m_lfsr[id];
        m_fill[id][addr] = 1'b1;
        m_cnt[id]++;
        lsb        = m_lfsr[id][0];
        m_lfsr[id] = m_lfsr[id] >> 1;
        if (lsb) m_lfsr[id] = m_lfsr[id] ^ 32'h80200003;
      end
      e.data = m_mem[id][addr];
    end
    if (id == 0) q_a.push_back(e);
    else q_b.push_back(e);
  endtask

  task automatic model_write(input int id, input int addr, input logic [31:0] data,
                             input int depth);
    if (addr < depth) begin
      if (!m_fill[id][addr]) m_cnt[id]++;
      m_fill[id][addr] = 1'b1;
      m_mem[id][addr]  = data;
    end
  endtask

  task automatic check_outputs(input int id);
    int          np;
    exp_t        q[$];
    string       pfx;
    logic        v, e, ev, ee;
    logic [31:0] d, ed;
    if (id == 0) begin np = 2; q = q_a; pfx = "a"; end
    else begin np = 3; q = q_b; pfx = "b"; end
    for (int p = 0; p < np; p++) begin
      ev = 1'b0; ee = 1'b0; ed = 32'h0;
      foreach (q[i]) begin
        if (q[i].due == cyc && q[i].port == p) begin
          ev = 1'b1; ee = q[i].err; ed = q[i].data;
        end
      end
      if (id == 0) begin v = rv_a[p]; e = re_a[p]; d = rd_a[p*32 +: 32]; end
      else begin v = rv_b[p]; e = re_b[p]; d = rd_b[p*32 +: 32]; end
      check_val($sformatf("%s_valid%0d", pfx, p), 64'(v), 64'(ev));
      check_val($sformatf("%s_err%0d", pfx, p), 64'(e), 64'(ee));
      check_val($sformatf("%s_data%0d", pfx, p), 64'(d), 64'(ed));
    end
    if (id == 0) check_val("a_fill_count", 64'(fc_a), 64'(m_cnt[0]));
    else check_val("b_fill_count", 64'(fc_b), 64'(m_cnt[1]));
    if (id == 0) begin
      for (int i = q_a.size() - 1; i >= 0; i--) if (q_a[i].due <= cyc) q_a.delete(i);
    end else begin
      for (int i = q_b.size() - 1; i >= 0; i--) if (q_b[i].due <= cyc) q_b.delete(i);
    end
  endtask

  task automatic idle_inputs();
    va = '0; vb = '0; we_b = 1'b0; waddr_b = '0; wdata_b = '0;
    for (int p = 0; p < 2; p++) aa[p] = '0;
    for (int p = 0; p < 3; p++) ab[p] = '0;
  endtask

  // Model the coming edge with the inputs now on the pins, then clock and compare.
  task automatic tick();
    if (rst_a_n) for (int p = 0; p < 2; p++) if (va[p]) model_read(0, p, int'(aa[p]), 1024, 1);
    if (rst_b_n) begin
      for (int p = 0; p < 3; p++) if (vb[p]) model_read(1, p, int'(ab[p]), 1000, 3);
      if (we_b) model_write(1, int'(waddr_b), wdata_b, 1000);
    end
    @(posedge clk);
    #1;
    cyc++;
    check_outputs(0);
    check_outputs(1);
  endtask

  task automatic idle_ticks(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      idle_inputs();
      tick();
    end
  endtask

  initial begin
    idle_inputs();
    model_reset(0);
    model_reset(1);
    #1;
    rst_a_n = 1'b0;
    rst_b_n = 1'b0;
    #2;
    check_val("rst_valid_a", 64'(rv_a), 64'h0);
    check_val("rst_fill_a", 64'(fc_a), 64'h0);
    check_val("rst_data_b", 64'(rd_b[63:0]), 64'h0);
    check_val("rst_fill_b", 64'(fc_b), 64'h0);
    idle_ticks(2);
    @(negedge clk);
    rst_a_n = 1'b1;
    rst_b_n = 1'b1;

    // First fill returns SEED, second the next Galois step.
    @(negedge clk); idle_inputs(); va = 2'b01; aa[0] = 10'd5; tick();
    check_val("t1_data", 64'(rd_a[31:0]), 64'hACE12468);
    check_val("t1_valid", 64'(rv_a[0]), 64'h1);
    check_val("t1_fill", 64'(fc_a), 64'h1);
    @(negedge clk); idle_inputs(); va = 2'b01; aa[0] = 10'd9; tick();
    check_val("t2_data9", 64'(rd_a[31:0]), 64'h56709234);
    @(negedge clk); idle_inputs(); va = 2'b01; aa[0] = 10'd5; tick();
    check_val("t2_data5", 64'(rd_a[31:0]), 64'hACE12468);
    check_val("t2_fill", 64'(fc_a), 64'h2);

    // Same new address on both ports: one fill, one LFSR step.
    @(negedge clk); idle_inputs(); va = 2'b11; aa[0] = 10'd3; aa[1] = 10'd3; tick();
    check_val("t3_p0", 64'(rd_a[31:0]), 64'h2B38491A);
    check_val("t3_p1", 64'(rd_a[63:32]), 64'h2B38491A);
    check_val("t3_fill", 64'(fc_a), 64'h3);
    @(negedge clk); idle_inputs(); va = 2'b01; aa[0] = 10'd4; tick();
    check_val("t3_next", 64'(rd_a[31:0]), 64'h159C248D);

    // Out-of-range read on the 1000-word instance, then the first fill still gets SEED.
    @(negedge clk); idle_inputs(); vb = 3'b001; ab[0] = 10'd1010; tick();
    idle_ticks(2);
    check_val("t5_err", 64'(re_b[0]), 64'h1);
    check_val("t5_valid", 64'(rv_b[0]), 64'h1);
    check_val("t5_data", 64'(rd_b[31:0]), 64'h0);
    check_val("t5_fill", 64'(fc_b), 64'h0);
    @(negedge clk); idle_inputs(); vb = 3'b001; ab[0] = 10'd2; tick();
    idle_ticks(2);
    check_val("t5_seed", 64'(rd_b[31:0]), 64'hACE12468);

    // Read and write of an unfilled address in one cycle: read sees LFSR, then the write.
    @(negedge clk); idle_inputs(); vb = 3'b010; ab[1] = 10'd7;
    we_b = 1'b1; waddr_b = 10'd7; wdata_b = 32'hDEADBEEF; tick();
    idle_ticks(2);
    check_val("t4_rd_lfsr", 64'(rd_b[63:32]), 64'h56709234);
    @(negedge clk); idle_inputs(); vb = 3'b100; ab[2] = 10'd7; tick();
    idle_ticks(2);
    check_val("t4_rd_wdata", 64'(rd_b[95:64]), 64'hDEADBEEF);

    // Back-to-back reads, then reset with responses still in flight.
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); idle_inputs(); vb = 3'b001; ab[0] = 10'(20 + i); tick();
    end
    #1;
    rst_b_n = 1'b0;
    #1;
    check_val("t6_drop_valid", 64'(rv_b), 64'h0);
    check_val("t6_drop_fill", 64'(fc_b), 64'h0);
    model_reset(1);
    q_b.delete();
    @(negedge clk); rst_b_n = 1'b1;
    idle_inputs(); vb = 3'b001; ab[0] = 10'd50; tick();
    idle_ticks(2);
    check_val("t6_seed", 64'(rd_b[31:0]), 64'hACE12468);

    // Randomised traffic on both instances with hits, duplicates, writes and out-of-range.
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      va = 2'($urandom_range(0, 3));
      for (int p = 0; p < 2; p++) aa[p] = 10'($urandom_range(0, 47));
      vb = 3'($urandom_range(0, 7));
      for (int p = 0; p < 3; p++)
        ab[p] = ($urandom_range(0, 3) == 0) ? 10'(990 + $urandom_range(0, 33))
                                            : 10'($urandom_range(0, 47));
      we_b    = ($urandom_range(0, 2) == 0);
      waddr_b = ($urandom_range(0, 4) == 0) ? 10'(995 + $urandom_range(0, 28))
                                            : 10'($urandom_range(0, 63));
      wdata_b = $urandom;
      tick();
    end
    idle_ticks(4);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
